mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of EX.
- Consumes the EX/MEM latch contents (ALU result, rt data, control bits) and performs loads and stores on an internal byte-addressed data memory.
- Registers the MEM/WB boundary. Its registered write-back value feeds EX's i_aluResult_WB forwarding input.
- Provides a combinational debug read port for the debug unit.

Parameters:
- NB_REG, 32, datapath width.
- NB_ADDR, 5, register-file index width.
- MEM_DEPTH, 64, data memory depth in 32-bit words (power of 2).
- NB_MEM_IDX, 6, word index width, log2(MEM_DEPTH).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  pipeline advance; 0 = stall (hold all state, suppress writes).
- i_alu_result  in  NB_REG  byte address / ALU result from EX/MEM.
- i_write_data  in  NB_REG  rt data to store.
- i_mem_read  in  1  load.
- i_mem_write  in  1  store.
- i_width  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- i_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- i_mem_to_reg  in  1  WB data select: 1 = load data, 0 = ALU result.
- i_reg_write  in  1  register write enable, passthrough.
- i_write_reg  in  NB_ADDR  destination register, passthrough.
- i_debug_addr  in  NB_MEM_IDX  debug word index.
- o_wb_data  out  NB_REG  registered write-back value.
- o_read_data  out  NB_REG  registered extended load data.
- o_alu_result  out  NB_REG  registered ALU result.
- o_write_reg  out  NB_ADDR  registered destination register.
- o_reg_write  out  1  registered register write enable.
- o_misaligned  out  1  registered misaligned-access flag.
- o_debug_data  out  NB_REG  combinational memory word at i_debug_addr.

Behaviour:
- Reset (async, i_rst_n=0): all registered outputs go to 0 immediately; every memory word is cleared to 0. Reset mid-operation discards any in-flight store.
- Memory is an array of MEM_DEPTH 32-bit words.
  - Word index = i_alu_result[NB_MEM_IDX+1:2]. Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
  - Little-endian byte lanes: lane 0 = bits [7:0].
- Read path is combinational from the array. The MEM/WB register captures the result on the same clock edge, so load latency is 1 cycle from presentation to o_read_data/o_wb_data.
- Store: synchronous on the rising edge when i_enable=1, i_mem_write=1 and the access is aligned.
  - Byte: i_write_data[7:0] goes to lane addr[1:0]; other lanes unchanged.
  - Half: i_write_data[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: the full 32 bits are written.
- Load extraction:
  - Byte: lane addr[1:0], 8 bits, extended per i_unsigned.
  - Half: 16 bits at addr[1], extended per i_unsigned.
  - Word: the full word; i_unsigned is ignored.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - Store is suppressed and memory is unchanged.
  - Load data = 0.
  - o_misaligned=1 for that one registered cycle.
- Simultaneous i_mem_read and i_mem_write: store takes precedence and o_read_data=0.
- When i_mem_read=0, o_read_data=0.
- o_wb_data = i_mem_to_reg ? extended load data : i_alu_result, registered.
- Stall (i_enable=0): all MEM/WB registers hold their values and no memory write occurs. o_debug_data remains live.
- Store followed by a load of the same address in the next cycle returns the new data, since the write completes before the combinational read.
- The debug port is read-only and has no side effects.

Test Plan:
- Reset: assert i_rst_n=0 mid-cycle -> all outputs 0 asynchronously; o_debug_data at index 3 reads 0x00000000.
- Word store/load: store 0xDEADBEEF at addr 0x0C, then next cycle load word at 0x0C -> o_read_data=o_wb_data=0xDEADBEEF one cycle later; o_debug_data(idx 3)=0xDEADBEEF.
- Byte/half extension:
  - Store byte 0x80 at addr 0x11 -> word idx 4 = 0x00008000.
  - Signed byte load -> 0xFFFFFF80; unsigned -> 0x00000080.
  - Signed half load at 0x10 -> 0xFFFF8000.
- Misaligned: word store of 0x12345678 at 0x22 -> memory idx 8 unchanged (0); o_misaligned=1 for one cycle; a following aligned load clears it to 0.
- Stall: i_enable=0 with a store of 0x55 to 0x04 and new ALU inputs -> memory idx 1 unchanged, all outputs hold previous values; raising i_enable performs the store.
- Passthrough/forward: i_mem_to_reg=0, i_alu_result=0x000000A0, i_write_reg=31, i_reg_write=1 -> next cycle o_wb_data=0xA0, o_write_reg=31, o_reg_write=1; address 0x100 wraps to word idx 0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: byte-addressed data memory with
// byte/half/word loads and stores, plus the registered MEM/WB boundary.
module mem_stage #(
   parameter int NB_REG     = 32,
   parameter int NB_ADDR    = 5,
   parameter int MEM_DEPTH  = 64,
   parameter int NB_MEM_IDX = 6
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic [NB_REG-1:0]     i_alu_result,
   input  logic [NB_REG-1:0]     i_write_data,
   input  logic                  i_mem_read,
   input  logic                  i_mem_write,
   input  logic [1:0]            i_width,
   input  logic                  i_unsigned,
   input  logic                  i_mem_to_reg,
   input  logic                  i_reg_write,
   input  logic [NB_ADDR-1:0]    i_write_reg,
   input  logic [NB_MEM_IDX-1:0] i_debug_addr,
   output logic [NB_REG-1:0]     o_wb_data,
   output logic [NB_REG-1:0]     o_read_data,
   output logic [NB_REG-1:0]     o_alu_result,
   output logic [NB_ADDR-1:0]    o_write_reg,
   output logic                  o_reg_write,
   output logic                  o_misaligned,
   output logic [NB_REG-1:0]     o_debug_data
);

   logic [NB_REG-1:0]     mem_q [MEM_DEPTH];
   logic [NB_MEM_IDX-1:0] word_idx;
   logic [1:0]            lane;
   logic                  is_byte;
   logic                  is_half;
   logic                  is_word;
   logic                  misaligned_c;
   logic                  store_en;
   logic [3:0]            byte_en;
   logic [NB_REG-1:0]     store_word;
   logic [NB_REG-1:0]     rd_word;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [NB_REG-1:0]     load_data;
   logic [NB_REG-1:0]     wb_c;

   logic [NB_REG-1:0]  wb_data_q,    wb_data_d;
   logic [NB_REG-1:0]  read_data_q,  read_data_d;
   logic [NB_REG-1:0]  alu_result_q, alu_result_d;
   logic [NB_ADDR-1:0] write_reg_q,  write_reg_d;
   logic               reg_write_q,  reg_write_d;
   logic               misaligned_q, misaligned_d;

   assign word_idx = i_alu_result[NB_MEM_IDX+1:2];
   assign lane     = i_alu_result[1:0];
   assign is_byte  = (i_width == 2'b00);
   assign is_half  = (i_width == 2'b01);
   assign is_word  = i_width[1];

   // Width 2'b11 is reserved and behaves exactly like a word access.
   assign misaligned_c = (i_mem_read | i_mem_write) &
                         ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
   assign store_en     = i_enable & i_mem_write & ~misaligned_c;

   always_comb begin
      byte_en    = 4'b1111;
      store_word = i_write_data;
      if (is_byte) begin
         byte_en    = 4'b0001 << lane;
         store_word = {4{i_write_data[7:0]}};
      end else if (is_half) begin
         byte_en    = lane[1] ? 4'b1100 : 4'b0011;
         store_word = {2{i_write_data[15:0]}};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      end else if (store_en) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem_q[word_idx][b*8 +: 8] <= store_word[b*8 +: 8];
         end
      end
   end

   assign rd_word = mem_q[word_idx];

   always_comb begin
      rd_byte = rd_word[7:0];
      case (lane)
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         2'd3:    rd_byte = rd_word[31:24];
         default: rd_byte = rd_word[7:0];
      endcase
      rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
   end

   // A store in the same cycle wins over the load, so load data reads as zero.
   always_comb begin
      load_data = '0;
      if (i_mem_read && !i_mem_write && !misaligned_c) begin
         if (is_byte)
            load_data = i_unsigned ? {{(NB_REG-8){1'b0}}, rd_byte}
                                   : {{(NB_REG-8){rd_byte[7]}}, rd_byte};
         else if (is_half)
            load_data = i_unsigned ? {{(NB_REG-16){1'b0}}, rd_half}
                                   : {{(NB_REG-16){rd_half[15]}}, rd_half};
         else
            load_data = rd_word;
      end
      wb_c = i_mem_to_reg ? load_data : i_alu_result;
   end

   always_comb begin
      wb_data_d    = wb_data_q;
      read_data_d  = read_data_q;
      alu_result_d = alu_result_q;
      write_reg_d  = write_reg_q;
      reg_write_d  = reg_write_q;
      misaligned_d = misaligned_q;
      if (i_enable) begin
         wb_data_d    = wb_c;
         read_data_d  = load_data;
         alu_result_d = i_alu_result;
         write_reg_d  = i_write_reg;
         reg_write_d  = i_reg_write;
         misaligned_d = misaligned_c;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wb_data_q    <= '0;
         read_data_q  <= '0;
         alu_result_q <= '0;
         write_reg_q  <= '0;
         reg_write_q  <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         wb_data_q    <= wb_data_d;
         read_data_q  <= read_data_d;
         alu_result_q <= alu_result_d;
         write_reg_q  <= write_reg_d;
         reg_write_q  <= reg_write_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign o_wb_data    = wb_data_q;
   assign o_read_data  = read_data_q;
   assign o_alu_result = alu_result_q;
   assign o_write_reg  = write_reg_q;
   assign o_reg_write  = reg_write_q;
   assign o_misaligned = misaligned_q;
   assign o_debug_data = mem_q[i_debug_addr];

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-array reference model feeding a scoreboard queue,
// directed scenarios followed by randomized traffic and a mid-cycle reset.
module tb_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [31:0] alu;
   logic [31:0] wdata;
   logic        mrd;
   logic        mwr;
   logic [1:0]  width;
   logic        uns;
   logic        mtr;
   logic        rw;
   logic [4:0]  wreg;
   logic [5:0]  dbg;
   logic [31:0] wb_o;
   logic [31:0] rd_o;
   logic [31:0] alu_o;
   logic [4:0]  wreg_o;
   logic        rw_o;
   logic        mis_o;
   logic [31:0] dbg_o;

   mem_stage dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_enable     (en),
      .i_alu_result (alu),
      .i_write_data (wdata),
      .i_mem_read   (mrd),
      .i_mem_write  (mwr),
      .i_width      (width),
      .i_unsigned   (uns),
      .i_mem_to_reg (mtr),
      .i_reg_write  (rw),
      .i_write_reg  (wreg),
      .i_debug_addr (dbg),
      .o_wb_data    (wb_o),
      .o_read_data  (rd_o),
      .o_alu_result (alu_o),
      .o_write_reg  (wreg_o),
      .o_reg_write  (rw_o),
      .o_misaligned (mis_o),
      .o_debug_data (dbg_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] wb;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  wreg;
      logic        rw;
      logic        mis;
      logic [31:0] dbg;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: flat little-endian byte array plus the expected MEM/WB state.
   logic [7:0]  mem_b [256];
   logic [31:0] m_wb, m_rd, m_alu;
   logic [4:0]  m_wreg;
   logic        m_rw, m_mis;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mword(input int idx);
      return {mem_b[idx*4+3], mem_b[idx*4+2], mem_b[idx*4+1], mem_b[idx*4]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
      m_wb = '0; m_rd = '0; m_alu = '0; m_wreg = '0; m_rw = 1'b0; m_mis = 1'b0;
   endtask

   task automatic cycle(input logic e, input logic r, input logic w, input logic [1:0] wd,
                        input logic u, input logic mt, input logic rwe, input logic [4:0] wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [5:0] di);
      int          ba;
      int          nbytes;
      logic        mis;
      logic [31:0] ld;
      logic [15:0] h;
      exp_t        ex;
      @(negedge clk);
      #1;
      en = e; mrd = r; mwr = w; width = wd; uns = u; mtr = mt; rw = rwe;
      wreg = wr; alu = a; wdata = d; dbg = di;
      if (e) begin
         ba  = int'(a[7:0]);
         mis = (r || w) && ((wd == 2'b01 && ba % 2 != 0) || (wd[1] && ba % 4 != 0));
         ld  = '0;
         if (r && !w && !mis) begin
            if (wd == 2'b00)
               ld = u ? {24'h0, mem_b[ba]} : {{24{mem_b[ba][7]}}, mem_b[ba]};
            else if (wd == 2'b01) begin
               h  = {mem_b[ba+1], mem_b[ba]};
               ld = u ? {16'h0, h} : {{16{h[15]}}, h};
            end else
               ld = {mem_b[ba+3], mem_b[ba+2], mem_b[ba+1], mem_b[ba]};
         end
         if (w && !mis) begin
            nbytes = (wd == 2'b00) ? 1 : (wd == 2'b01) ? 2 : 4;
            for (int i = 0; i < nbytes; i++) mem_b[ba+i] = d[8*i +: 8];
         end
         m_wb = mt ? ld : a; m_rd = ld; m_alu = a; m_wreg = wr; m_rw = rwe; m_mis = mis;
      end
      ex = '{wb: m_wb, rd: m_rd, alu: m_alu, wreg: m_wreg, rw: m_rw, mis: m_mis,
             dbg: mword(int'(di))};
      exp_q.push_back(ex);
      @(posedge clk);
      #2;
   endtask

   // Monitor: each clock edge presents a new MEM/WB state to compare.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_wb_data",    wb_o,          e.wb);
         check("sb_read_data",  rd_o,          e.rd);
         check("sb_alu_result", alu_o,         e.alu);
         check("sb_write_reg",  32'(wreg_o),   32'(e.wreg));
         check("sb_reg_write",  32'(rw_o),     32'(e.rw));
         check("sb_misaligned", 32'(mis_o),    32'(e.mis));
         check("sb_debug",      dbg_o,         e.dbg);
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; alu = '0; wdata = '0; mrd = 1'b0; mwr = 1'b0;
      width = 2'b10; uns = 1'b0; mtr = 1'b0; rw = 1'b0; wreg = '0; dbg = 6'd3;
      model_reset();
      #1;
      check("reset_wb", wb_o, 32'h0);
      check("reset_debug3", dbg_o, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Word store then load, store-to-load forwarding through memory.
      cycle(1, 0, 1, 2'b10, 0, 0, 0, 5'd0, 32'h0C, 32'hDEADBEEF, 6'd3);
      check("word_store_debug", dbg_o, 32'hDEADBEEF);
      cycle(1, 1, 0, 2'b10, 0, 1, 1, 5'd5, 32'h0C, 32'h0, 6'd3);
      check("word_load_rd", rd_o, 32'hDEADBEEF);
      check("word_load_wb", wb_o, 32'hDEADBEEF);

      // Byte store and sign/zero extension.
      cycle(1, 0, 1, 2'b00, 0, 0, 0, 5'd0, 32'h11, 32'h80, 6'd4);
      check("byte_store_debug", dbg_o, 32'h00008000);
      cycle(1, 1, 0, 2'b00, 0, 1, 1, 5'd2, 32'h11, 32'h0, 6'd4);
      check("byte_load_signed", rd_o, 32'hFFFFFF80);
      cycle(1, 1, 0, 2'b00, 1, 1, 1, 5'd2, 32'h11, 32'h0, 6'd4);
      check("byte_load_unsigned", rd_o, 32'h00000080);
      cycle(1, 1, 0, 2'b01, 0, 1, 1, 5'd2, 32'h10, 32'h0, 6'd4);
      check("half_load_signed", rd_o, 32'hFFFF8000);

      // Misaligned word store is dropped and flagged for one cycle.
      cycle(1, 0, 1, 2'b10, 0, 0, 0, 5'd0, 32'h22, 32'h12345678, 6'd8);
      check("misaligned_flag", 32'(mis_o), 32'd1);
      check("misaligned_mem", dbg_o, 32'h0);
      cycle(1, 1, 0, 2'b10, 0, 1, 1, 5'd3, 32'h20, 32'h0, 6'd8);
      check("misaligned_clear", 32'(mis_o), 32'd0);

      // Passthrough, then a stall that must hold everything.
      cycle(1, 0, 0, 2'b10, 0, 0, 1, 5'd31, 32'hA0, 32'h0, 6'd1);
      check("pass_wb", wb_o, 32'hA0);
      check("pass_wreg", 32'(wreg_o), 32'd31);
      check("pass_rw", 32'(rw_o), 32'd1);
      cycle(0, 0, 1, 2'b00, 0, 0, 0, 5'd7, 32'h04, 32'h55, 6'd1);
      check("stall_wb_hold", wb_o, 32'hA0);
      check("stall_wreg_hold", 32'(wreg_o), 32'd31);
      check("stall_no_store", dbg_o, 32'h0);
      cycle(1, 0, 1, 2'b00, 0, 0, 0, 5'd7, 32'h04, 32'h55, 6'd1);
      check("unstall_store", dbg_o, 32'h00000055);

      // Address wrap and simultaneous read/write.
      cycle(1, 0, 1, 2'b10, 0, 0, 0, 5'd0, 32'h100, 32'h11223344, 6'd0);
      check("wrap_store_idx0", dbg_o, 32'h11223344);
      cycle(1, 1, 0, 2'b10, 0, 1, 1, 5'd4, 32'h0, 32'h0, 6'd0);
      check("wrap_load", rd_o, 32'h11223344);
      cycle(1, 1, 1, 2'b10, 0, 1, 1, 5'd4, 32'h0C, 32'h0BADF00D, 6'd3);
      check("rdwr_read_zero", rd_o, 32'h0);
      check("rdwr_store", dbg_o, 32'h0BADF00D);

      for (int n = 0; n < 500; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
         cycle(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               a, $urandom, 6'($urandom_range(0, 63)));
      end

      // Mid-cycle reset while a store is presented: store is discarded.
      cycle(1, 0, 1, 2'b10, 0, 0, 1, 5'd9, 32'h0C, 32'hCAFEF00D, 6'd3);
      @(negedge clk);
      #1;
      en = 1'b1; mrd = 1'b0; mwr = 1'b1; width = 2'b10; alu = 32'h0C;
      wdata = 32'h5A5A5A5A; dbg = 6'd3;
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset_wb", wb_o, 32'h0);
      check("midreset_wreg", 32'(wreg_o), 32'd0);
      check("midreset_rw", 32'(rw_o), 32'd0);
      check("midreset_debug3", dbg_o, 32'h0);
      model_reset();
      @(posedge clk);
      #2;
      check("midreset_store_dropped", dbg_o, 32'h0);
      @(negedge clk);
      #1;
      en = 1'b0; mwr = 1'b0;
      rst_n = 1'b1;
      cycle(1, 1, 0, 2'b10, 0, 1, 1, 5'd1, 32'h0C, 32'h0, 6'd3);
      check("post_reset_load", rd_o, 32'h0);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
